spi_reg_ctrl: RTL and testbench
===============================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter addrsz, default 7, SPI register address width.
REQ-002 SHALL have parameter payload, default 8, register data width.
REQ-003 SHALL have parameter nregs, default 16, implemented registers (2..2**addrsz).
REQ-004 SHALL have parameter id_val, default 8'hA5, constant value of register 0.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 reg_addr  input  addrsz  address from SPI client.
REQ-008 addr_dv  input  1  address valid from SPI client; high for rest of transaction.
REQ-009 rw_out  input  1  SPI direction: 1 read, 0 write.
REQ-010 rx_d  input  payload  write data from SPI client.
REQ-011 rxdv  input  1  write data valid from SPI client.
REQ-012 tx_d  output  payload  read data to SPI client.
REQ-013 tx_en  output  1  read-data enable to SPI client.
REQ-014 lcl_req  input  1  local-port request, held until granted.
REQ-015 lcl_we  input  1  local-port write (1) / read (0).
REQ-016 lcl_addr  input  addrsz  local-port address.
REQ-017 lcl_wdata  input  payload  local-port write data.
REQ-018 lcl_gnt  output  1  one-cycle grant pulse.
REQ-019 lcl_rdata  output  payload  local read data, valid with lcl_gnt.
REQ-020 cfg_out  output  nregs*payload  all registers flattened, reg n at bits [n*payload +: payload].
REQ-021 err_cnt  output  8  saturating error count.

Function
REQ-022 FSM states SHALL be IDLE, RD_ACT, WR_WAIT, WR_COMMIT, WR_DONE.
REQ-023 An addr_dv rising edge (registered previous value 0, current 1) in IDLE SHALL start an SPI transaction; rw_out and reg_addr sampled that cycle.
REQ-024 Read start: next cycle state RD_ACT, tx_d = register[reg_addr] (0 if reg_addr >= nregs), tx_en = 1.
REQ-025 tx_d SHALL be a snapshot held constant through RD_ACT; later register writes do not alter it.
REQ-026 RD_ACT: on addr_dv = 0, next cycle tx_en = 0, tx_d = 0, state IDLE.
REQ-027 Write start: state WR_WAIT; on rxdv rising edge -> WR_COMMIT (exactly one cycle) -> WR_DONE.
REQ-028 WR_COMMIT SHALL write rx_d to register[address] when 1 <= address < nregs; address 0 ignored silently.
REQ-029 WR_DONE: on addr_dv = 0 -> IDLE.
REQ-030 WR_WAIT: addr_dv = 0 before rxdv rise SHALL abort to IDLE, no write, err_cnt +1.
REQ-031 SPI read or write with address >= nregs SHALL increment err_cnt once per transaction.
REQ-032 err_cnt SHALL saturate at 255; a local write to address 0 SHALL clear it.
REQ-033 Local port: request sampled each cycle; granted in any cycle state is not WR_COMMIT (SPI has fixed priority).
REQ-034 Local grant: lcl_gnt pulses 1 the cycle after sampling; write takes effect that same edge; lcl_rdata = register[lcl_addr] (0 if out of range), else 0.
REQ-035 A held lcl_req SHALL get one grant per two cycles max (request must be re-sampled after lcl_gnt).
REQ-036 Register 0 SHALL always read id_val; cfg_out slice 0 = id_val.
REQ-037 addr_dv falling in any state other than IDLE SHALL return FSM to IDLE within one cycle, tx_en low.

Reset
REQ-038 reset_n low SHALL force: state IDLE, registers 1..nregs-1 = 0, tx_d = 0, tx_en = 0, lcl_gnt = 0, lcl_rdata = 0, err_cnt = 0, edge registers = 0.
REQ-039 Reset mid-transaction SHALL discard it; addr_dv already high at reset release SHALL NOT start a transaction (needs a fresh rising edge).

Verification
REQ-040 SPI write addr 3 data 8'h5C -> after rxdv rise, cfg_out[31:24] = 8'h5C one cycle after WR_COMMIT; err_cnt 0.
REQ-041 SPI read addr 3 after REQ-040 -> tx_d = 8'h5C, tx_en 1 until addr_dv falls, then both 0.
REQ-042 SPI read addr 0 -> tx_d = 8'hA5; SPI write addr 0 data 8'hFF -> register 0 stays 8'hA5.
REQ-043 Local write addr 5 requested in the WR_COMMIT cycle of SPI write addr 5 data 8'h11, lcl_wdata 8'h22 -> SPI writes first, lcl_gnt one cycle later, final reg 5 = 8'h22.
REQ-044 SPI write addr 20 (nregs 16), then write with addr_dv dropped before rxdv -> no register change, err_cnt = 2; local write addr 0 -> err_cnt = 0.
REQ-045 Reset asserted in RD_ACT -> tx_en 0, tx_d 0 immediately; addr_dv held high through release -> FSM stays IDLE.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// SPI client register bank with a lower-priority local access port.
// Register 0 is a read-only ID. Registers 1..nregs-1 are read/write.
// SPI transactions are framed by addr_dv: a rising edge starts one, and a
// falling edge ends it. Write data is committed one cycle after rxdv rises.
// Handshake: lcl_req is held until lcl_gnt pulses for one cycle. lcl_rdata is
// valid only in that cycle. Write data takes effect on the same edge that
// raises lcl_gnt. A request is never granted while an SPI write commits.
module spi_reg_ctrl #(
    parameter int                 addrsz  = 7,
    parameter int                 payload = 8,
    parameter int                 nregs   = 16,
    parameter logic [payload-1:0] id_val  = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [addrsz-1:0]        reg_addr,
    input  logic                     addr_dv,
    input  logic                     rw_out,
    input  logic [payload-1:0]       rx_d,
    input  logic                     rxdv,
    output logic [payload-1:0]       tx_d,
    output logic                     tx_en,
    input  logic                     lcl_req,
    input  logic                     lcl_we,
    input  logic [addrsz-1:0]        lcl_addr,
    input  logic [payload-1:0]       lcl_wdata,
    output logic                     lcl_gnt,
    output logic [payload-1:0]       lcl_rdata,
    output logic [nregs*payload-1:0] cfg_out,
    output logic [7:0]               err_cnt,
    output logic [2:0]               dbg_state
);

    localparam int IW = (nregs > 2) ? $clog2(nregs) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ACT    = 3'd1,
        WR_WAIT   = 3'd2,
        WR_COMMIT = 3'd3,
        WR_DONE   = 3'd4
    } state_t;

    state_t               state_q;
    logic                 addr_dv_q, rxdv_q, dv_armed_q;
    logic [addrsz-1:0]    addr_q;
    logic [payload-1:0]   wdata_q;
    logic [payload-1:0]   regs_q [1:nregs-1];
    logic [payload-1:0]   tx_d_q, lcl_rdata_q;
    logic                 tx_en_q, lcl_gnt_q;
    logic [7:0]           err_q, err_d;

    logic addr_rise, rxdv_rise, spi_oor, lcl_take, lcl_clr, err_inc;

    function automatic logic in_range(input logic [addrsz-1:0] a);
        in_range = (32'(a) < nregs);
    endfunction

    function automatic logic [payload-1:0] rd(input logic [addrsz-1:0] a);
        if (a == '0)
            rd = id_val;
        else if (in_range(a))
            rd = regs_q[a[IW-1:0]];
        else
            rd = '0;
    endfunction

    // dv_armed_q blocks a start when addr_dv is already high at reset release.
    assign addr_rise = addr_dv && !addr_dv_q && dv_armed_q;
    assign rxdv_rise = rxdv && !rxdv_q;
    assign spi_oor   = !in_range(reg_addr);
    assign lcl_take  = lcl_req && !lcl_gnt_q && (state_q != WR_COMMIT);
    assign lcl_clr   = lcl_take && lcl_we && (lcl_addr == '0);
    assign err_inc   = ((state_q == IDLE) && addr_rise && spi_oor) ||
                       ((state_q == WR_WAIT) && !addr_dv);

    // Next error count: a local clear goes first, then a saturating increment.
    always_comb begin
        err_d = err_q;
        if (lcl_clr)
            err_d = '0;
        if (err_inc && (err_d != 8'hFF))
            err_d = err_d + 8'd1;
    end

    // Edge-detect history for addr_dv and rxdv.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_dv_q  <= 1'b0;
            rxdv_q     <= 1'b0;
            dv_armed_q <= 1'b0;
            err_q      <= '0;
        end else begin
            addr_dv_q  <= addr_dv;
            rxdv_q     <= rxdv;
            dv_armed_q <= dv_armed_q | ~addr_dv;
            err_q      <= err_d;
        end
    end

    // SPI transaction FSM with the registered read-data snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            tx_d_q  <= '0;
            tx_en_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (addr_rise) begin
                        addr_q <= reg_addr;
                        if (rw_out) begin
                            state_q <= RD_ACT;
                            tx_d_q  <= rd(reg_addr);
                            tx_en_q <= 1'b1;
                        end else begin
                            state_q <= WR_WAIT;
                        end
                    end
                end
                RD_ACT: begin
                    if (!addr_dv) begin
                        state_q <= IDLE;
                        tx_en_q <= 1'b0;
                        tx_d_q  <= '0;
                    end
                end
                WR_WAIT: begin
                    if (!addr_dv) begin
                        state_q <= IDLE;
                    end else if (rxdv_rise) begin
                        state_q <= WR_COMMIT;
                        wdata_q <= rx_d;
                    end
                end
                WR_COMMIT: state_q <= addr_dv ? WR_DONE : IDLE;
                WR_DONE: begin
                    if (!addr_dv)
                        state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    tx_en_q <= 1'b0;
                    tx_d_q  <= '0;
                end
            endcase
        end
    end

    // Register file writes (SPI commit, local write) and the local grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < nregs; i++)
                regs_q[i] <= '0;
            lcl_gnt_q   <= 1'b0;
            lcl_rdata_q <= '0;
        end else begin
            lcl_gnt_q   <= lcl_take;
            lcl_rdata_q <= (lcl_take && !lcl_we) ? rd(lcl_addr) : '0;
            if ((state_q == WR_COMMIT) && (addr_q != '0) && in_range(addr_q))
                regs_q[addr_q[IW-1:0]] <= wdata_q;
            if (lcl_take && lcl_we && (lcl_addr != '0) && in_range(lcl_addr))
                regs_q[lcl_addr[IW-1:0]] <= lcl_wdata;
        end
    end

    assign cfg_out[payload-1:0] = id_val;
    for (genvar g = 1; g < nregs; g++) begin : g_cfg
        assign cfg_out[g*payload +: payload] = regs_q[g];
    end

    assign tx_d      = tx_d_q;
    assign tx_en     = tx_en_q;
    assign lcl_gnt   = lcl_gnt_q;
    assign lcl_rdata = lcl_rdata_q;
    assign err_cnt   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed scenarios plus randomized SPI/local traffic,
// checked against an array-based register model with a scoreboard.
module tb_spi_reg_ctrl;

    localparam int NREGS = 16;
    localparam logic [7:0] ID = 8'hA5;

    logic         clk, reset_n;
    logic [6:0]   reg_addr, lcl_addr;
    logic         addr_dv, rw_out, rxdv, lcl_req, lcl_we;
    logic [7:0]   rx_d, lcl_wdata, tx_d, lcl_rdata, err_cnt;
    logic         tx_en, lcl_gnt;
    logic [127:0] cfg_out;
    logic [2:0]   dbg_state;

    spi_reg_ctrl dut (
        .clk(clk), .reset_n(reset_n), .reg_addr(reg_addr), .addr_dv(addr_dv),
        .rw_out(rw_out), .rx_d(rx_d), .rxdv(rxdv), .tx_d(tx_d), .tx_en(tx_en),
        .lcl_req(lcl_req), .lcl_we(lcl_we), .lcl_addr(lcl_addr),
        .lcl_wdata(lcl_wdata), .lcl_gnt(lcl_gnt), .lcl_rdata(lcl_rdata),
        .cfg_out(cfg_out), .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    // Clock and reference model state.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_regs [NREGS];
    int         m_err;
    logic [7:0] exp_tx_q [$];
    logic [7:0] exp_lcl_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input int a);
        if (a == 0) return ID;
        if (a < NREGS) return m_regs[a];
        return 8'h00;
    endfunction

    function automatic logic [127:0] m_cfg();
        logic [127:0] c;
        for (int i = 0; i < NREGS; i++) c[i*8 +: 8] = m_read(i);
        return c;
    endfunction

    task automatic m_err_inc();
        if (m_err < 255) m_err++;
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_err = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_cfg"}, cfg_out, m_cfg());
        check({tag, "_err"}, err_cnt, 128'(m_err));
    endtask

    // Monitor: pops expected read data whenever the DUT presents it.
    initial begin
        logic       prev_en;
        logic [7:0] cur_tx;
        prev_en = 1'b0;
        cur_tx  = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_en && !prev_en) begin
                if (exp_tx_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL tx_unexpected: got tx_d %0h with nothing expected", tx_d);
                end else begin
                    cur_tx = exp_tx_q.pop_front();
                    check("tx_d_start", tx_d, cur_tx);
                end
            end else if (tx_en) begin
                check("tx_d_hold", tx_d, cur_tx);
            end else if (prev_en) begin
                check("tx_d_clear", tx_d, 0);
            end
            if (lcl_gnt) begin
                if (exp_lcl_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL lcl_unexpected: got grant with rdata %0h, none expected", lcl_rdata);
                end else begin
                    check("lcl_rdata", lcl_rdata, exp_lcl_q.pop_front());
                end
            end
            prev_en = tx_en;
        end
    end

    // Driver tasks: each begins and ends on a falling clock edge.
    task automatic spi_write(input int a, input logic [7:0] d);
        @(negedge clk);
        addr_dv = 1'b1; rw_out = 1'b0; reg_addr = 7'(a); rx_d = d; rxdv = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rxdv = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (a >= NREGS) m_err_inc();
        else if (a != 0) m_regs[a] = d;
        check("spi_wr_cfg", cfg_out, m_cfg());
        addr_dv = 1'b0; rxdv = 1'b0;
        @(negedge clk);
    endtask

    task automatic spi_read(input int a);
        @(negedge clk);
        addr_dv = 1'b1; rw_out = 1'b1; reg_addr = 7'(a);
        exp_tx_q.push_back(m_read(a));
        if (a >= NREGS) m_err_inc();
        repeat ($urandom_range(1, 4)) @(negedge clk);
        addr_dv = 1'b0;
        @(negedge clk);
    endtask

    task automatic spi_abort(input int a);
        @(negedge clk);
        addr_dv = 1'b1; rw_out = 1'b0; reg_addr = 7'(a); rxdv = 1'b0;
        @(negedge clk);
        addr_dv = 1'b0;
        if (a >= NREGS) m_err_inc();
        m_err_inc();
        @(negedge clk);
    endtask

    task automatic lcl_op(input logic we, input int a, input logic [7:0] d);
        bit got;
        @(negedge clk);
        lcl_req = 1'b1; lcl_we = we; lcl_addr = 7'(a); lcl_wdata = d;
        exp_lcl_q.push_back(we ? 8'h00 : m_read(a));
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = lcl_gnt;
        end
        lcl_req = 1'b0;
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL lcl_timeout: got no grant, expected grant within 20 cycles");
        end
        if (we) begin
            if (a == 0) m_err = 0;
            else if (a < NREGS) m_regs[a] = d;
        end
    endtask

    // Stimulus sequence and final report.
    initial begin
        int         gcount, kind, a;
        logic [7:0] d;
        reset_n = 1'b0; addr_dv = 1'b0; rw_out = 1'b0; reg_addr = '0; rx_d = '0;
        rxdv = 1'b0; lcl_req = 1'b0; lcl_we = 1'b0; lcl_addr = '0; lcl_wdata = '0;
        m_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_tx_en", tx_en, 0);
        check("rst_tx_d", tx_d, 0);
        check("rst_lcl_gnt", lcl_gnt, 0);
        check("rst_lcl_rdata", lcl_rdata, 0);
        check("rst_state_idle", dbg_state, 0);
        check_state("rst");

        // Basic write then read-back, ID register behaviour.
        spi_write(3, 8'h5C);
        check("wr3_slice", cfg_out[31:24], 8'h5C);
        check_state("wr3");
        spi_read(3);
        spi_read(0);
        spi_write(0, 8'hFF);
        check("id_slice", cfg_out[7:0], 8'hA5);
        check_state("wr0");

        // Read snapshot stays fixed while a local write changes the register.
        @(negedge clk);
        addr_dv = 1'b1; rw_out = 1'b1; reg_addr = 7'd3;
        exp_tx_q.push_back(m_read(3));
        @(negedge clk);
        d = m_regs[3] ^ 8'hFF;
        lcl_req = 1'b1; lcl_we = 1'b1; lcl_addr = 7'd3; lcl_wdata = d;
        exp_lcl_q.push_back(8'h00);
        @(negedge clk);
        check("snap_gnt", lcl_gnt, 1);
        lcl_req = 1'b0;
        m_regs[3] = d;
        @(negedge clk);
        addr_dv = 1'b0;
        repeat (2) @(negedge clk);
        check_state("snap");

        // Local write collides with the SPI commit cycle: SPI first, local later.
        @(negedge clk);
        addr_dv = 1'b1; rw_out = 1'b0; reg_addr = 7'd5; rx_d = 8'h11; rxdv = 1'b0;
        @(negedge clk);
        rxdv = 1'b1;
        @(negedge clk);
        lcl_req = 1'b1; lcl_we = 1'b1; lcl_addr = 7'd5; lcl_wdata = 8'h22;
        exp_lcl_q.push_back(8'h00);
        @(negedge clk);
        check("prio_spi_first", cfg_out[47:40], 8'h11);
        check("prio_no_gnt", lcl_gnt, 0);
        @(negedge clk);
        check("prio_gnt", lcl_gnt, 1);
        check("prio_local_last", cfg_out[47:40], 8'h22);
        lcl_req = 1'b0; addr_dv = 1'b0; rxdv = 1'b0;
        m_regs[5] = 8'h22;
        @(negedge clk);
        check_state("prio");

        // Error counting: out-of-range write, aborted write, local clear.
        spi_write(20, 8'h3C);
        spi_abort(4);
        check("err_two", err_cnt, 2);
        check_state("err");
        lcl_op(1'b1, 0, 8'h00);
        @(negedge clk);
        check("err_clear", err_cnt, 0);

        // A held local request gets at most one grant every two cycles.
        @(negedge clk);
        lcl_req = 1'b1; lcl_we = 1'b0; lcl_addr = 7'd5;
        repeat (3) exp_lcl_q.push_back(m_read(5));
        gcount = 0;
        repeat (6) begin
            @(negedge clk);
            if (lcl_gnt) gcount++;
        end
        lcl_req = 1'b0;
        check("held_req_grants", gcount, 3);
        @(negedge clk);

        // Reset during a read; addr_dv high across release must not start.
        @(negedge clk);
        addr_dv = 1'b1; rw_out = 1'b1; reg_addr = 7'd3;
        exp_tx_q.push_back(m_read(3));
        @(negedge clk);
        #2 reset_n = 1'b0;
        m_reset();
        #1;
        check("rd_rst_tx_en", tx_en, 0);
        check("rd_rst_tx_d", tx_d, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rel_no_start_en", tx_en, 0);
        check("rel_no_start_state", dbg_state, 0);
        addr_dv = 1'b0;
        @(negedge clk);
        check_state("post_rst");
        spi_read(3);

        // Randomized mix of SPI and local transactions.
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 4);
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 127) : $urandom_range(0, 15);
            d = 8'($urandom_range(0, 255));
            case (kind)
                0: spi_write(a, d);
                1: spi_read(a);
                2: spi_abort(a);
                3: lcl_op(1'b1, a, d);
                default: lcl_op(1'b0, a, d);
            endcase
            @(negedge clk);
            check_state("rand");
        end

        // Saturation at 255, then clear.
        for (int n = 0; n < 130; n++) spi_abort(100);
        check("err_sat", err_cnt, 255);
        spi_abort(100);
        check("err_sat_hold", err_cnt, 255);
        check_state("sat");
        lcl_op(1'b1, 0, 8'h00);
        @(negedge clk);
        check("err_sat_clear", err_cnt, 0);

        repeat (3) @(negedge clk);
        check("tx_queue_drain", exp_tx_q.size(), 0);
        check("lcl_queue_drain", exp_lcl_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
